// File: rtl/hc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hc_pkg: shared HardCloud request types and arbiter state encoding    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hc_pkg;

    localparam int HC_BUFFER_SIZE   = 2;
    localparam int HC_REQUEST_DEPTH = 8;

    typedef enum logic [2:0] {
        e_REQUEST_IDLE         = 3'd0,
        e_REQUEST_READ         = 3'd1,
        e_REQUEST_WRITE        = 3'd2,
        e_REQUEST_READ_STREAM  = 3'd3,
        e_REQUEST_WRITE_STREAM = 3'd4
    } t_request_cmd;

    typedef logic [15:0] t_request_size;

    typedef struct packed {
        t_request_cmd  cmd;
        logic [7:0]    buffer_id;
        t_request_size size;
        logic [31:0]   offset;
    } t_request_control;

    typedef struct packed {
        logic          empty;
        logic          full;
        t_request_size count;
    } t_request_status;

    typedef enum logic [1:0] {
        S_ARB_IDLE  = 2'd0,
        S_ARB_ISSUE = 2'd1,
        S_ARB_WAIT  = 2'd2
    } t_arb_state;

    typedef logic [$clog2(HC_BUFFER_SIZE)-1:0] t_arb_port;

endpackage
`default_nettype wire

// File: rtl/hc_request_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hc_request_fifo: per-port command FIFO with registered status        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hc_request_fifo
    import hc_pkg::*;
#(
    parameter int FIFO_DEPTH = HC_REQUEST_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  t_request_control i_push_data,
    input  logic             i_pop,
    output t_request_control o_head,
    output t_request_status  o_status
);

    localparam int AW = $clog2(FIFO_DEPTH);

    t_request_control r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    t_request_size    r_count;
    logic             r_empty;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    t_request_size    w_count_nxt;

    // A pop frees the slot the concurrent push lands in, so push is legal when full.
    assign w_push = i_push & (~r_full | i_pop);
    assign w_pop  = i_pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + t_request_size'(1);
            2'b01:   w_count_nxt = r_count - t_request_size'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == t_request_size'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_status = '{empty: r_empty, full: r_full, count: r_count};

endmodule
`default_nettype wire

// File: rtl/hc_request_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hc_request_arbiter: round-robin sharing of the HardCloud requestor   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hc_request_arbiter
    import hc_pkg::*;
#(
    parameter int NUM_REQ    = HC_BUFFER_SIZE,
    parameter int FIFO_DEPTH = HC_REQUEST_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  t_request_control [NUM_REQ-1:0]     req_control,
    output logic [NUM_REQ-1:0]                 req_ready,
    output t_request_status [NUM_REQ-1:0]      req_status,
    output logic                               cmd_valid,
    output t_request_control                   cmd_control,
    output logic [$clog2(NUM_REQ)-1:0]         cmd_port,
    input  logic                               cmd_ready,
    input  logic                               cmd_done,
    output logic                               busy
);

    localparam int PW = $clog2(NUM_REQ);

    t_arb_state                        r_state;
    t_arb_state                        w_state_nxt;
    logic [PW-1:0]                     r_rr;
    t_request_control                  r_cmd_control;
    logic [PW-1:0]                     r_cmd_port;

    logic [NUM_REQ-1:0]                w_push;
    logic [NUM_REQ-1:0]                w_pop;
    logic [NUM_REQ-1:0]                w_nonempty;
    t_request_control [NUM_REQ-1:0]    w_head;
    logic [PW-1:0]                     w_grant;
    logic                              w_found;
    logic                              w_grant_en;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        hc_request_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_push      (w_push[i]),
            .i_push_data (req_control[i]),
            .i_pop       (w_pop[i]),
            .o_head      (w_head[i]),
            .o_status    (req_status[i])
        );

        assign req_ready[i]  = ~req_status[i].full;
        // IDLE commands complete the handshake but never enter the queue.
        assign w_push[i]     = req_valid[i] & req_ready[i] &
                               (req_control[i].cmd != e_REQUEST_IDLE);
        assign w_nonempty[i] = ~req_status[i].empty;
        assign w_pop[i]      = w_grant_en & (w_grant == PW'(i));
    end

    // First pass covers ports at or above the pointer, second pass the wrap.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_nonempty[j] && (PW'(j) >= r_rr)) begin
                w_found = 1'b1;
                w_grant = PW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_nonempty[j]) begin
                w_found = 1'b1;
                w_grant = PW'(j);
            end
        end
    end

    assign w_grant_en = (r_state == S_ARB_IDLE) & enable & w_found;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ARB_IDLE:  if (w_grant_en) w_state_nxt = S_ARB_ISSUE;
            S_ARB_ISSUE: if (cmd_ready)  w_state_nxt = S_ARB_WAIT;
            S_ARB_WAIT:  if (cmd_done)   w_state_nxt = S_ARB_IDLE;
            default:                     w_state_nxt = S_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_ARB_IDLE;
            r_rr          <= '0;
            r_cmd_control <= '0;
            r_cmd_port    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_en) begin
                r_cmd_control <= w_head[w_grant];
                r_cmd_port    <= w_grant;
                r_rr          <= (w_grant == PW'(NUM_REQ - 1)) ? '0 : w_grant + PW'(1);
            end
        end
    end

    assign cmd_valid   = (r_state == S_ARB_ISSUE);
    assign cmd_control = r_cmd_control;
    assign cmd_port    = r_cmd_port;
    assign busy        = (r_state != S_ARB_IDLE) | (|w_nonempty);

endmodule
`default_nettype wire

// File: tb/tb_hc_request_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hc_request_arbiter: directed, table and randomized checks         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hc_request_arbiter;
    import hc_pkg::*;

    localparam int N = 2;
    localparam int D = 8;
    localparam logic [17:0] ST_RST = 18'h20000;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       enable;
    logic [N-1:0]               req_valid;
    t_request_control [N-1:0]   req_control;
    logic [N-1:0]               req_ready;
    t_request_status [N-1:0]    req_status;
    logic                       cmd_valid;
    t_request_control           cmd_control;
    logic [0:0]                 cmd_port;
    logic                       cmd_ready;
    logic                       cmd_done;
    logic                       busy;

    always #5 clk = ~clk;

    hc_request_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_control (req_control),
        .req_ready   (req_ready),
        .req_status  (req_status),
        .cmd_valid   (cmd_valid),
        .cmd_control (cmd_control),
        .cmd_port    (cmd_port),
        .cmd_ready   (cmd_ready),
        .cmd_done    (cmd_done),
        .busy        (busy)
    );

    int n_pass   = 0;
    int n_checks = 0;
    logic hold1;
    t_request_control got_ctl[$];
    logic [0:0]       got_port[$];

    typedef struct {
        logic        v0;
        logic        done;
        logic        exp_valid;
        logic        exp_busy;
        logic [15:0] exp_cnt0;
    } vec_t;
    vec_t tv[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic t_request_control mk(input t_request_cmd c, input int id,
                                            input int sz, input int off);
        t_request_control r;
        r.cmd       = c;
        r.buffer_id = 8'(id);
        r.size      = 16'(sz);
        r.offset    = 32'(off);
        return r;
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        req_valid   = '0;
        req_control = '0;
        cmd_ready   = 1'b0;
        cmd_done    = 1'b0;
        hold1       = 1'b0;
        got_ctl.delete();
        got_port.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Acts as the requestor: accepts immediately, completes dly cycles after issue.
    task automatic serve(input int n, input int dly);
        int   cnt = 0;
        int   cyc = 0;
        logic acc;
        cmd_ready = 1'b1;
        while ((got_ctl.size() < n || cnt > 0) && cyc < 500) begin
            cmd_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) cmd_done = 1'b1;
            end
            if (cmd_valid) begin
                got_ctl.push_back(cmd_control);
                got_port.push_back(cmd_port);
                cnt = dly;
            end
            acc = hold1 && req_ready[1];
            tick();
            cyc++;
            if (acc) begin
                req_valid[1] = 1'b0;
                hold1        = 1'b0;
            end
        end
        cmd_done = 1'b0;
        chk("serve_timeout", 64'(cyc < 500), 64'd1);
    endtask

    // Reference model: per-port queues plus the single outstanding command.
    t_request_control mq[N][$];
    int               m_phase;
    t_request_control m_ctl;
    int               m_port;
    int               m_rr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Idle after reset with enable high
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk("idle_ready", 64'(req_ready), 64'(2'b11));
            chk("idle_status", 64'(req_status), 64'({ST_RST, ST_RST}));
            chk("idle_valid", 64'(cmd_valid), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            tick();
        end

        // Single command latency table
        for (int c = 0; c < 12; c++) begin
            tv[c].v0        = (c == 0);
            tv[c].done      = (c == 10);
            tv[c].exp_valid = (c == 2);
            tv[c].exp_busy  = (c >= 1 && c <= 10);
            tv[c].exp_cnt0  = (c == 1) ? 16'd1 : 16'd0;
        end
        do_reset();
        enable         = 1'b1;
        cmd_ready      = 1'b1;
        req_control[0] = mk(e_REQUEST_READ_STREAM, 0, 64, 'h100);
        for (int c = 0; c < 12; c++) begin
            req_valid[0] = tv[c].v0;
            cmd_done     = tv[c].done;
            chk($sformatf("t2_valid_c%0d", c), 64'(cmd_valid), 64'(tv[c].exp_valid));
            chk($sformatf("t2_busy_c%0d", c), 64'(busy), 64'(tv[c].exp_busy));
            chk($sformatf("t2_cnt0_c%0d", c), 64'(req_status[0].count), 64'(tv[c].exp_cnt0));
            if (c == 2) begin
                chk("t2_ctl", 64'(cmd_control), 64'(mk(e_REQUEST_READ_STREAM, 0, 64, 'h100)));
                chk("t2_port", 64'(cmd_port), 64'd0);
            end
            tick();
        end
        cmd_done = 1'b0;

        // Both ports push three commands together
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid      = 2'b11;
            req_control[0] = mk(e_REQUEST_READ, k, 8, k * 64);
            req_control[1] = mk(e_REQUEST_WRITE, 16 + k, 8, k * 64);
            tick();
        end
        req_valid = '0;
        serve(6, 4);
        for (int k = 0; k < 6; k++) begin
            if (k < got_ctl.size()) begin
                chk($sformatf("rr_port_%0d", k), 64'(got_port[k]), 64'(k % 2));
                chk($sformatf("rr_id_%0d", k), 64'(got_ctl[k].buffer_id),
                    64'((k % 2) * 16 + k / 2));
            end else begin
                chk($sformatf("rr_missing_%0d", k), 64'(got_ctl.size()), 64'(k + 1));
            end
        end
        chk("rr_status_end", 64'(req_status), 64'({ST_RST, ST_RST}));
        chk("rr_busy_end", 64'(busy), 64'd0);

        // Fill port 1 while disabled, hold a ninth request
        do_reset();
        for (int k = 0; k < 8; k++) begin
            req_valid[1]   = 1'b1;
            req_control[1] = mk(e_REQUEST_WRITE_STREAM, k, 32, k);
            tick();
        end
        req_control[1] = mk(e_REQUEST_WRITE_STREAM, 8, 32, 8);
        hold1 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("full_status", 64'(req_status[1]), 64'(18'h10008));
            chk("full_ready", 64'(req_ready), 64'(2'b01));
            chk("full_no_issue", 64'(cmd_valid), 64'd0);
            tick();
        end
        enable = 1'b1;
        serve(9, 2);
        chk("full_issued", 64'(got_ctl.size()), 64'd9);
        chk("held_accepted", 64'(hold1), 64'd0);
        for (int k = 0; k < 9 && k < got_ctl.size(); k++) begin
            chk($sformatf("full_order_%0d", k), 64'({got_port[k], got_ctl[k].buffer_id}),
                64'({1'b1, 8'(k)}));
        end
        chk("full_status_end", 64'(req_status), 64'({ST_RST, ST_RST}));

        // IDLE command is dropped; stray cmd_done in idle is harmless
        do_reset();
        enable         = 1'b1;
        req_valid[0]   = 1'b1;
        req_control[0] = mk(e_REQUEST_IDLE, 3, 4, 5);
        chk("idlecmd_ready", 64'(req_ready[0]), 64'd1);
        tick();
        req_valid[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("idlecmd_status", 64'(req_status[0]), 64'(ST_RST));
            chk("idlecmd_valid", 64'(cmd_valid), 64'd0);
            tick();
        end
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        chk("stray_done_busy", 64'(busy), 64'd0);
        req_valid[0]   = 1'b1;
        req_control[0] = mk(e_REQUEST_READ, 9, 4, 5);
        chk("post_stray_c0", 64'(cmd_valid), 64'd0);
        tick();
        req_valid[0] = 1'b0;
        chk("post_stray_c1", 64'(cmd_valid), 64'd0);
        tick();
        chk("post_stray_c2", 64'(cmd_valid), 64'd1);

        // Reset while a command is outstanding
        do_reset();
        enable    = 1'b1;
        cmd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[0]   = 1'b1;
            req_control[0] = mk(e_REQUEST_READ, k, 16, k);
            tick();
        end
        req_valid[0] = 1'b0;
        chk("prerst_cnt", 64'(req_status[0]), 64'(18'h00002));
        chk("prerst_wait", 64'({cmd_valid, busy}), 64'(2'b01));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_ready", 64'(req_ready), 64'(2'b11));
        chk("rst_status", 64'(req_status), 64'({ST_RST, ST_RST}));
        chk("rst_cmd", 64'({cmd_valid, cmd_port, busy}), 64'd0);
        chk("rst_ctl", 64'(cmd_control), 64'd0);
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rst_late_done", 64'({cmd_valid, busy}), 64'd0);
            tick();
        end

        // Randomized run against the queue model
        do_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_phase = 0;
        m_ctl   = '0;
        m_port  = 0;
        m_rr    = 0;
        enable  = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0]  exp_ready;
            logic [35:0]   exp_st;
            logic          any;
            logic [N-1:0]  do_push;
            int            pct;
            pct = ((cyc / 500) % 2 == 1) ? 12 : 70;
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            for (int i = 0; i < N; i++) begin
                req_valid[i]   = ($urandom_range(0, 99) < pct);
                req_control[i] = mk(t_request_cmd'($urandom_range(0, 4)),
                                    int'($urandom_range(0, 255)), int'($urandom), int'($urandom));
            end
            cmd_ready = 1'($urandom_range(0, 1));
            cmd_done  = (m_phase == 2) && ($urandom_range(0, 3) == 0);

            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                exp_ready[i]          = (mq[i].size() < D);
                exp_st[i*18 +: 18]    = {mq[i].size() == 0, mq[i].size() == D, 16'(mq[i].size())};
                if (mq[i].size() != 0) any = 1'b1;
                do_push[i] = req_valid[i] && exp_ready[i] && (req_control[i].cmd != e_REQUEST_IDLE);
            end
            chk("rand_ctrl", 64'({req_ready, req_status, cmd_valid, busy, cmd_port}),
                64'({exp_ready, exp_st, m_phase == 1, (m_phase != 0) || any, 1'(m_port)}));
            chk("rand_cmd", 64'(cmd_control), 64'(m_ctl));

            if (m_phase == 0 && enable && any) begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_rr + k) % N;
                    if (m_phase == 0 && mq[p].size() != 0) begin
                        m_ctl   = mq[p].pop_front();
                        m_port  = p;
                        m_rr    = (p + 1) % N;
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1 && cmd_ready) begin
                m_phase = 2;
            end else if (m_phase == 2 && cmd_done) begin
                m_phase = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (do_push[i]) mq[i].push_back(req_control[i]);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
